// File: rtl/alu_exec_stage.sv
// One-entry registered ALU execute stage with a valid/ready handshake on both sides.
// Result and flags are produced one cycle after a request is accepted.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic             invert_b;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_full;
  logic             sum_ovf;
  logic [WIDTH-1:0] exec_result;
  logic             exec_carry;
  logic             exec_ovf;
  logic             exec_illegal;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Single adder shared by add, sub and slt; sub/slt use A + ~B + 1.
  always_comb begin
    invert_b = (alu_control == OP_SUB) || (alu_control == OP_SLT);
    b_eff    = invert_b ? ~src_b : src_b;
    sum_full = {1'b0, src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, invert_b};
    sum_ovf  = (src_a[WIDTH-1] == b_eff[WIDTH-1]) &&
               (sum_full[WIDTH-1] != src_a[WIDTH-1]);
  end

  always_comb begin
    exec_result  = '0;
    exec_carry   = 1'b0;
    exec_ovf     = 1'b0;
    exec_illegal = 1'b0;
    case (alu_control)
      OP_ADD, OP_SUB: begin
        exec_result = sum_full[WIDTH-1:0];
        exec_carry  = sum_full[WIDTH];
        exec_ovf    = sum_ovf;
      end
      OP_AND: exec_result = src_a & src_b;
      OP_OR:  exec_result = src_a | src_b;
      // N xor V keeps the signed compare correct when A-B overflows.
      OP_SLT: exec_result = {{(WIDTH-1){1'b0}}, sum_full[WIDTH-1] ^ sum_ovf};
      default: exec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    illegal_d   = illegal_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = exec_result;
      zero_d      = (exec_result == '0);
      carry_d     = exec_carry;
      overflow_d  = exec_ovf;
      illegal_d   = exec_illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomised and directed bench for alu_exec_stage; an arithmetic reference model
// feeds a scoreboard queue that a free-running monitor checks against the DUT.
module tb_alu_exec_stage;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             illegal;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];

  alu_exec_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .carry(carry), .overflow(overflow), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain signed/unsigned integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint ua, ub, sa, sb, s, u;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e = '0;
    case (op)
      3'd0: begin
        u = ua + ub;
        s = sa + sb;
        e.res = u[31:0];
        e.c = (u >= 64'sh1_0000_0000);
        e.v = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
      end
      3'd1: begin
        u = ua - ub;
        s = sa - sb;
        e.res = u[31:0];
        e.c = (ua >= ub);
        e.v = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd5: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  // Scoreboard producer: record every accepted request at the clock edge.
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready)
      sb_q.push_back(model(alu_control, src_a, src_b));
  end

  always @(negedge rst_n) sb_q.delete();

  // Monitor: on the falling edge compare the presented entry; pop it if it drains next edge.
  always @(negedge clk) begin
    exp_t e;
    tests++;
    if (out_valid !== (sb_q.size() != 0)) begin
      fails++;
      $display("[TB] FAIL mon_valid: got %b expected %b (t=%0t)", out_valid, sb_q.size() != 0, $time);
    end
    tests++;
    if (in_ready !== (!out_valid || out_ready)) begin
      fails++;
      $display("[TB] FAIL mon_in_ready: got %b expected %b (t=%0t)", in_ready, !out_valid || out_ready, $time);
    end
    if (out_valid === 1'b1 && sb_q.size() != 0) begin
      e = sb_q[0];
      tests++;
      if ({result, zero, carry, overflow, illegal} !== {e.res, e.z, e.c, e.v, e.ill}) begin
        fails++;
        $display("[TB] FAIL mon_data: got res=%h z%b c%b v%b ill%b expected res=%h z%b c%b v%b ill%b (t=%0t)",
                 result, zero, carry, overflow, illegal, e.res, e.z, e.c, e.v, e.ill, $time);
      end
      if (out_ready) void'(sb_q.pop_front());
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic ordy);
    in_valid    = v;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    out_ready   = ordy;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [31:0] eres,
                             input logic ez, input logic ec, input logic eov, input logic eill);
    tests++;
    if ({out_valid, result, zero, carry, overflow, illegal} !== {ev, eres, ez, ec, eov, eill}) begin
      fails++;
      $display("[TB] FAIL %s: got v%b res=%h z%b c%b v%b ill%b expected v%b res=%h z%b c%b v%b ill%b",
               name, out_valid, result, zero, carry, overflow, illegal, ev, eres, ez, ec, eov, eill);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  ops4 [4];
    logic [31:0] res4 [4];
    ops4 = '{3'd2, 3'd3, 3'd0, 3'd1};
    res4 = '{32'h0000_00F0, 32'h0000_FFF0, 32'h0001_00E0, 32'h0000_E100};

    rst_n = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    #3;
    checkOutput("reset_state", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkBit("reset_in_ready", in_ready, 1'b1);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Add wrap-around.
    applyStimulus(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    cycle();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    checkOutput("add_wrap", 1'b1, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle();

    // Sub overflow, then slt at the same boundary.
    applyStimulus(1'b1, 3'd1, 32'h8000_0000, 32'd1, 1'b1);
    cycle();
    checkOutput("sub_ovf", 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd5, 32'h8000_0000, 32'd1, 1'b1);
    cycle();
    checkOutput("slt_boundary", 1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    cycle();
    checkBit("idle_after_slt", out_valid, 1'b0);

    // Back-to-back requests with no bubbles.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, ops4[i], 32'h0000_F0F0, 32'h0000_0FF0, 1'b1);
      cycle();
      checkOutput($sformatf("b2b_%0d", i), 1'b1, res4[i], 1'b0, (ops4[i] == 3'd1), 1'b0, 1'b0);
      checkBit($sformatf("b2b_ready_%0d", i), in_ready, 1'b1);
    end
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    cycle();
    checkBit("b2b_drained", out_valid, 1'b0);

    // Backpressure for three cycles, then drain and accept together.
    applyStimulus(1'b1, 3'd0, 32'd10, 32'd20, 1'b1);
    cycle();
    checkOutput("bp_first", 1'b1, 32'd30, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd1, 32'd100, 32'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkOutput($sformatf("bp_hold_%0d", i), 1'b1, 32'd30, 1'b0, 1'b0, 1'b0, 1'b0);
      checkBit($sformatf("bp_in_ready_%0d", i), in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    checkBit("bp_release_ready", in_ready, 1'b1);
    cycle();
    checkOutput("bp_replace", 1'b1, 32'd99, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    cycle();

    // Illegal code followed by a legal add.
    applyStimulus(1'b1, 3'b110, 32'd5, 32'd3, 1'b1);
    cycle();
    checkOutput("illegal_110", 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd0, 32'd2, 32'd3, 1'b1);
    cycle();
    checkOutput("legal_after_illegal", 1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while a result is held under backpressure.
    applyStimulus(1'b1, 3'd0, 32'd7, 32'd8, 1'b1);
    cycle();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    cycle();
    checkOutput("held_before_reset", 1'b1, 32'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkBit("reset_ready", in_ready, 1'b1);
    applyStimulus(1'b1, 3'd0, 32'd1, 32'd1, 1'b1);
    cycle();
    checkBit("no_accept_in_reset", out_valid, 1'b0);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    rst_n = 1'b1;
    cycle();
    cycle();
    checkOutput("no_reappear", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomised traffic, checked by the monitor.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
                    pickOperand(), pickOperand(), $urandom_range(0, 9) < 7);
      cycle();
    end
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    cycle();
    cycle();
    checkBit("final_empty", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
